// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: one-hot FSM encoding
// and parity mode selectors.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_rx_ext_if.sv
// Bus-side receive interface: FIFO head, error flags, pop strobe and status.
interface uart_rx_ext_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    input  rx_en,
    output rx_ready, rx_data, rx_perr, rx_ferr, rx_overrun, rx_busy
  );

  modport slave (
    output rx_en,
    input  rx_ready, rx_data, rx_perr, rx_ferr, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with a registered head entry; head reads back as zero while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             full, empty, push_ok, pop_ok;
  logic [WIDTH-1:0] head_nxt;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);
  assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);

  // The entry being written this cycle becomes the head when it lands on the next read slot
  assign head_nxt = (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? din
                                                                    : mem[rd_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head     <= '0;
      overrun  <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      head_vld <= (wr_nxt != rd_nxt);
      head     <= (wr_nxt != rd_nxt) ? head_nxt : '0;
      overrun  <= push && full && !pop;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with 3-sample majority vote, false-start rejection,
// per-frame parity/framing flags and a small receive FIFO.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          uart_rx_clk,
  input  logic          rxd,
  uart_rx_ext_if.master rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int FW = DATA_BITS + 2;

  localparam logic [TW-1:0] T_MID_M = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_MID_P = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
  localparam logic          S_LAST  = 1'(STOP_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_err(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d ^ p) != (PARITY_MODE == PARITY_ODD);
  endfunction

  logic                 rxd_p0, rxd_p1;
  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 busy, perr, ferr, push;
  logic                 samp_mid_m, samp_mid, maj;
  logic [DATA_BITS-1:0] data_q;
  logic [FW-1:0]        frame_w;
  logic                 head_vld, overrun;
  logic [FW-1:0]        head;

  // Stage p0/p1: two-flop synchronizer, preset to line idle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  // Majority resolves on the MID+1 tick, once all three samples are available
  assign maj = maj3(samp_mid_m, samp_mid, rxd_p1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      busy     <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      push     <= 1'b0;
    end else begin
      push <= 1'b0;
      if (uart_rx_clk) begin
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
        case (state)
          ST_IDLE: begin
            tick_cnt <= '0;
            if (!rxd_p1) begin
              state <= ST_START;
              busy  <= 1'b1;
              perr  <= 1'b0;
              ferr  <= 1'b0;
            end
          end
          ST_START: begin
            if (tick_cnt == T_MID_P && maj) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (tick_cnt == T_LAST) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            if (tick_cnt == T_LAST) begin
              if (bit_idx == B_LAST) begin
                state    <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                stop_idx <= 1'b0;
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end
          end
          ST_PARITY: begin
            if (tick_cnt == T_MID_P) perr <= par_err(data_q, maj);
            if (tick_cnt == T_LAST) begin
              state    <= ST_STOP;
              stop_idx <= 1'b0;
            end
          end
          ST_STOP: begin
            if (tick_cnt == T_MID_P) begin
              ferr <= ferr | ~maj;
              // Leaving half a bit early keeps back-to-back frames aligned
              if (stop_idx == S_LAST) begin
                push  <= 1'b1;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else if (tick_cnt == T_LAST) begin
              stop_idx <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (uart_rx_clk) begin
      if (tick_cnt == T_MID_M) samp_mid_m <= rxd_p1;
      if (tick_cnt == T_MID)   samp_mid   <= rxd_p1;
      if (tick_cnt == T_MID_P) begin
        if (state == ST_DATA) data_q[bit_idx] <= maj;
        if (state == ST_STOP) frame_w <= {ferr | ~maj, perr, data_q};
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .push     (push),
    .din      (frame_w),
    .pop      (rx.rx_en),
    .head_vld (head_vld),
    .head     (head),
    .overrun  (overrun)
  );

  assign rx.rx_ready   = head_vld;
  assign rx.rx_data    = head[DATA_BITS-1:0];
  assign rx.rx_perr    = head[DATA_BITS];
  assign rx.rx_ferr    = head[DATA_BITS+1];
  assign rx.rx_overrun = overrun;
  assign rx.rx_busy    = busy;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: 8N1, 8E1 and 8N2 receivers driven by
// hand-built frames at 16x oversampling, one tick every 4 sys_clk.
module tb_uart_rx_ext;
  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rx_clk;
  logic [1:0] tdiv      = 2'd0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
  int         ncmp = 0, nerr = 0, ovr_cnt = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) tdiv <= tdiv + 2'd1;
  assign uart_rx_clk = (tdiv == 2'd3);

  uart_rx_ext_if #(.DATA_BITS(8)) rx_a ();
  uart_rx_ext_if #(.DATA_BITS(8)) rx_b ();
  uart_rx_ext_if #(.DATA_BITS(8)) rx_c ();

  uart_rx_ext #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx_clk(uart_rx_clk), .rxd(rxd_a), .rx(rx_a));
  uart_rx_ext #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx_clk(uart_rx_clk), .rxd(rxd_b), .rx(rx_b));
  uart_rx_ext #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    dut_c (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx_clk(uart_rx_clk), .rxd(rxd_c), .rx(rx_c));

  always @(posedge sys_clk) if (rx_a.rx_overrun) ovr_cnt <= ovr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_rxd(input int d, input logic v);
    case (d)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  // Bits go out LSB first, 64 sys_clk each; bit gbit is inverted for one tick at mid-bit
  task automatic send_frame(input int d, input logic [15:0] fb, input int n, input int gbit);
    for (int i = 0; i < n; i++) begin
      set_rxd(d, fb[i]);
      if (i == gbit) begin
        wait_clk(32);
        set_rxd(d, ~fb[i]);
        wait_clk(4);
        set_rxd(d, fb[i]);
        wait_clk(28);
      end else begin
        wait_clk(64);
      end
    end
    set_rxd(d, 1'b1);
  endtask

  task automatic pop(input int d);
    case (d)
      0:       rx_a.rx_en = 1'b1;
      1:       rx_b.rx_en = 1'b1;
      default: rx_c.rx_en = 1'b1;
    endcase
    wait_clk(1);
    rx_a.rx_en = 1'b0;
    rx_b.rx_en = 1'b0;
    rx_c.rx_en = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    rx_a.rx_en = 1'b0;
    rx_b.rx_en = 1'b0;
    rx_c.rx_en = 1'b0;
    wait_clk(3);
    check("rst_ready",   32'(rx_a.rx_ready),   32'd0);
    check("rst_data",    32'(rx_a.rx_data),    32'd0);
    check("rst_busy",    32'(rx_a.rx_busy),    32'd0);
    check("rst_overrun", 32'(rx_a.rx_overrun), 32'd0);
    check("rst_flags",   32'({rx_a.rx_perr, rx_a.rx_ferr}), 32'd0);
    sys_rst_n = 1'b1;
    wait_clk(8);

    // 8N1 0xA5
    send_frame(0, {1'b1, 8'hA5, 1'b0}, 10, -1);
    wait_clk(8);
    check("t1_ready", 32'(rx_a.rx_ready), 32'd1);
    check("t1_data",  32'(rx_a.rx_data),  32'hA5);
    check("t1_perr",  32'(rx_a.rx_perr),  32'd0);
    check("t1_ferr",  32'(rx_a.rx_ferr),  32'd0);
    pop(0);
    check("t1_pop_ready", 32'(rx_a.rx_ready), 32'd0);

    // 8E1: 0x07 has three ones, so even parity bit is 1
    send_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);
    wait_clk(8);
    check("t2_good_ready", 32'(rx_b.rx_ready), 32'd1);
    check("t2_good_data",  32'(rx_b.rx_data),  32'h07);
    check("t2_good_perr",  32'(rx_b.rx_perr),  32'd0);
    pop(1);
    send_frame(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
    wait_clk(8);
    check("t2_bad_data", 32'(rx_b.rx_data), 32'h07);
    check("t2_bad_perr", 32'(rx_b.rx_perr), 32'd1);
    check("t2_bad_ferr", 32'(rx_b.rx_ferr), 32'd0);
    pop(1);
    check("t2_pop_ready", 32'(rx_b.rx_ready), 32'd0);

    // False start: 4 ticks low
    set_rxd(0, 1'b0);
    wait_clk(16);
    set_rxd(0, 1'b1);
    check("t3_glitch_busy", 32'(rx_a.rx_busy), 32'd1);
    wait_clk(64);
    check("t3_glitch_idle",  32'(rx_a.rx_busy),  32'd0);
    check("t3_glitch_ready", 32'(rx_a.rx_ready), 32'd0);

    // One corrupted sample in data bit 3 (frame index 4)
    send_frame(0, {1'b1, 8'h5A, 1'b0}, 10, 4);
    wait_clk(8);
    check("t3_vote_ready", 32'(rx_a.rx_ready), 32'd1);
    check("t3_vote_data",  32'(rx_a.rx_data),  32'h5A);
    pop(0);

    // Stop bit held low
    send_frame(0, {1'b0, 8'h81, 1'b0}, 10, -1);
    wait_clk(8);
    check("t4_ferr_data", 32'(rx_a.rx_data), 32'h81);
    check("t4_ferr",      32'(rx_a.rx_ferr), 32'd1);
    pop(0);
    wait_clk(64);
    check("t4_ferr_idle",  32'(rx_a.rx_busy),  32'd0);
    check("t4_ferr_empty", 32'(rx_a.rx_ready), 32'd0);

    // 8N2: good frame, then second stop low
    send_frame(2, {1'b1, 1'b1, 8'h42, 1'b0}, 11, -1);
    wait_clk(8);
    check("t4_2stop_good_data", 32'(rx_c.rx_data), 32'h42);
    check("t4_2stop_good_ferr", 32'(rx_c.rx_ferr), 32'd0);
    pop(2);
    send_frame(2, {1'b0, 1'b1, 8'h42, 1'b0}, 11, -1);
    wait_clk(8);
    check("t4_2stop_bad_ready", 32'(rx_c.rx_ready), 32'd1);
    check("t4_2stop_bad_ferr",  32'(rx_c.rx_ferr),  32'd1);
    pop(2);

    // Fill the 4-entry FIFO, then overflow with a fifth frame
    for (int k = 1; k <= 4; k++) send_frame(0, {1'b1, 8'(k), 1'b0}, 10, -1);
    wait_clk(8);
    check("t5_full_ovr",  32'(ovr_cnt),       32'd0);
    check("t5_full_head", 32'(rx_a.rx_data),  32'h01);
    send_frame(0, {1'b1, 8'h05, 1'b0}, 10, -1);
    wait_clk(8);
    check("t5_overrun_pulse", 32'(ovr_cnt),      32'd1);
    check("t5_overrun_head",  32'(rx_a.rx_data), 32'h01);
    for (int k = 1; k <= 4; k++) begin
      check("t5_pop_ready", 32'(rx_a.rx_ready), 32'd1);
      check("t5_pop_data",  32'(rx_a.rx_data),  32'(k));
      pop(0);
    end
    check("t5_drained", 32'(rx_a.rx_ready), 32'd0);

    // Reset mid-DATA with two bytes queued
    send_frame(0, {1'b1, 8'h11, 1'b0}, 10, -1);
    send_frame(0, {1'b1, 8'h22, 1'b0}, 10, -1);
    wait_clk(8);
    check("t6_queued", 32'(rx_a.rx_data), 32'h11);
    send_frame(0, {3'b001, 1'b0}, 4, -1);
    set_rxd(0, 1'b0);
    wait_clk(32);
    check("t6_busy_before", 32'(rx_a.rx_busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(rx_a.rx_ready), 32'd0);
    check("t6_rst_data",  32'(rx_a.rx_data),  32'd0);
    check("t6_rst_busy",  32'(rx_a.rx_busy),  32'd0);
    check("t6_rst_flags", 32'({rx_a.rx_perr, rx_a.rx_ferr, rx_a.rx_overrun}), 32'd0);
    set_rxd(0, 1'b1);
    wait_clk(4);
    sys_rst_n = 1'b1;
    wait_clk(64);
    check("t6_after_rel_ready", 32'(rx_a.rx_ready), 32'd0);
    send_frame(0, {1'b1, 8'h3C, 1'b0}, 10, -1);
    wait_clk(8);
    check("t6_3c_ready", 32'(rx_a.rx_ready), 32'd1);
    check("t6_3c_data",  32'(rx_a.rx_data),  32'h3C);
    check("t6_3c_flags", 32'({rx_a.rx_perr, rx_a.rx_ferr}), 32'd0);
    pop(0);
    check("t6_3c_empty", 32'(rx_a.rx_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
